// File: rtl/stg_ma_pkg.sv
// Shared widths, opcode classes and the write-back bundle
// for the memory-access stage.
package stg_ma_pkg;

   localparam int HBIT_ADDR   = 47;
   localparam int HBIT_DATA   = 23;
   localparam int HBIT_OPC    = 7;
   localparam int HBIT_TGT_GP = 3;
   localparam int HBIT_TGT_SR = 1;
   localparam int HBIT_TGT_AR = 1;

   localparam logic [HBIT_OPC:0] OPC_NOP   = 8'h00;
   localparam logic [HBIT_OPC:0] OPC_ADDUR = 8'h01;
   localparam logic [HBIT_OPC:0] OPC_LDUR  = 8'h30;
   localparam logic [HBIT_OPC:0] OPC_STUR  = 8'h40;

   // Class match on the upper opcode nibble; the hazard unit
   // uses the same two helpers.
   function automatic logic opc_is_load(logic [HBIT_OPC:0] opc);
      return (opc & 8'hF0) == 8'h30;
   endfunction

   function automatic logic opc_is_store(logic [HBIT_OPC:0] opc);
      return (opc & 8'hF0) == 8'h40;
   endfunction

   typedef struct packed {
      logic [HBIT_ADDR:0]   pc;
      logic [HBIT_DATA:0]   instr;
      logic [HBIT_OPC:0]    opc;
      logic [HBIT_TGT_GP:0] tgt_gp;
      logic                 tgt_gp_we;
      logic [HBIT_TGT_SR:0] tgt_sr;
      logic                 tgt_sr_we;
      logic [HBIT_TGT_AR:0] tgt_ar;
      logic                 tgt_ar_we;
      logic [HBIT_DATA:0]   result;
      logic [HBIT_ADDR:0]   ar_result;
      logic [HBIT_ADDR:0]   sr_result;
   } wb_t;

   // A bubble keeps the data fields but can never write back.
   function automatic wb_t wb_bubble(wb_t w);
      wb_t r;
      r           = w;
      r.tgt_gp_we = 1'b0;
      r.tgt_sr_we = 1'b0;
      r.tgt_ar_we = 1'b0;
      r.opc       = '0;
      r.instr     = '0;
      return r;
   endfunction

endpackage

// File: rtl/stg_ma_if.sv
// Data-memory req/ack bus between the MA stage (master)
// and the memory (slave).
interface stg_ma_if;
   import stg_ma_pkg::*;

   logic               ow_mem_req;
   logic               ow_mem_we;
   logic [HBIT_ADDR:0] ow_mem_addr;
   logic [HBIT_DATA:0] ow_mem_wdata;
   logic               iw_mem_ack;
   logic [HBIT_DATA:0] iw_mem_rdata;

   modport master (
      output ow_mem_req,
      output ow_mem_we,
      output ow_mem_addr,
      output ow_mem_wdata,
      input  iw_mem_ack,
      input  iw_mem_rdata
   );

   modport slave (
      input  ow_mem_req,
      input  ow_mem_we,
      input  ow_mem_addr,
      input  ow_mem_wdata,
      output iw_mem_ack,
      output iw_mem_rdata
   );

endinterface

// File: rtl/ma_req_fsm.sv
// Request FSM of the MA stage: owns state, the ack timeout,
// the memory request and the upstream stall.
module ma_req_fsm #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic iw_clk,
   input  logic iw_rst,
   input  logic mem_op,
   input  logic iw_stall,
   input  logic iw_mem_ack,
   output logic req,
   output logic err,
   output logic stall,
   output logic start,
   output logic pass,
   output logic ack_commit,
   output logic ack_hold,
   output logic done_commit,
   output logic abort
);

   localparam int unsigned CW =
      (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_WAIT = S_WAIT,
      ST_DONE = S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last;
   logic          stall_raw;

   assign last  = (cnt == LAST);
   assign stall = stall_raw & ~iw_rst;

   // Decode per-cycle datapath controls and the upstream stall.
   // The stall drops whenever WAIT ends (ack or abort) so the
   // consumed instruction leaves the input and is not reissued.
   always_comb begin
      stall_raw   = 1'b0;
      start       = 1'b0;
      pass        = 1'b0;
      ack_commit  = 1'b0;
      ack_hold    = 1'b0;
      done_commit = 1'b0;
      abort       = 1'b0;
      case (state)
         ST_IDLE: begin
            start     = mem_op & ~iw_stall;
            pass      = ~mem_op & ~iw_stall;
            stall_raw = iw_stall | mem_op;
         end
         ST_WAIT: begin
            ack_commit = iw_mem_ack & ~iw_stall;
            ack_hold   = iw_mem_ack & iw_stall;
            abort      = ~iw_mem_ack & last;
            stall_raw  = ~(iw_mem_ack | last);
         end
         ST_DONE: begin
            done_commit = ~iw_stall;
            stall_raw   = 1'b1;
         end
         default: stall_raw = 1'b0;
      endcase
   end

   // State, timeout counter, request and error pulse.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         req   <= 1'b0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
                  req   <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (iw_mem_ack) begin
                  req   <= 1'b0;
                  cnt   <= '0;
                  state <= iw_stall ? ST_DONE : ST_IDLE;
               end else if (last) begin
                  req   <= 1'b0;
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               if (!iw_stall) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/stg_ma.sv
// Memory-access stage: issues one req/ack transaction per
// load/store and registers the write-back bundle.
module stg_ma
   import stg_ma_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic [HBIT_ADDR:0]   iw_pc,
   output logic [HBIT_ADDR:0]   ow_pc,
   input  logic [HBIT_DATA:0]   iw_instr,
   output logic [HBIT_DATA:0]   ow_instr,
   input  logic [HBIT_OPC:0]    iw_opc,
   output logic [HBIT_OPC:0]    ow_opc,
   input  logic [HBIT_TGT_GP:0] iw_tgt_gp,
   input  logic                 iw_tgt_gp_we,
   output logic [HBIT_TGT_GP:0] ow_tgt_gp,
   output logic                 ow_tgt_gp_we,
   input  logic [HBIT_TGT_SR:0] iw_tgt_sr,
   input  logic                 iw_tgt_sr_we,
   output logic [HBIT_TGT_SR:0] ow_tgt_sr,
   output logic                 ow_tgt_sr_we,
   input  logic [HBIT_TGT_AR:0] iw_tgt_ar,
   input  logic                 iw_tgt_ar_we,
   output logic [HBIT_TGT_AR:0] ow_tgt_ar,
   output logic                 ow_tgt_ar_we,
   input  logic [HBIT_ADDR:0]   iw_addr,
   input  logic [HBIT_DATA:0]   iw_result,
   output logic [HBIT_DATA:0]   ow_result,
   input  logic [HBIT_ADDR:0]   iw_ar_result,
   output logic [HBIT_ADDR:0]   ow_ar_result,
   input  logic [HBIT_ADDR:0]   iw_sr_result,
   output logic [HBIT_ADDR:0]   ow_sr_result,
   stg_ma_if.master             mem,
   output logic                 ow_mem_err,
   input  logic                 iw_flush,
   input  logic                 iw_stall,
   output logic                 ow_stall
);

   wb_t                in_wb;
   wb_t                out_q;
   wb_t                pend_q;
   logic [HBIT_ADDR:0] addr_q;
   logic [HBIT_DATA:0] wdata_q;
   logic               we_q;
   logic               mem_op;
   logic               req;
   logic               start;
   logic               pass;
   logic               ack_commit;
   logic               ack_hold;
   logic               done_commit;
   logic               abort;

   // Stores write no GP register; loads take the memory data.
   function automatic wb_t commit_wb(
      wb_t                p,
      logic [HBIT_DATA:0] rd,
      logic               st
   );
      wb_t r;
      r = p;
      if (st) r.tgt_gp_we = 1'b0;
      else    r.result    = rd;
      return r;
   endfunction

   assign in_wb = '{
      pc:        iw_pc,
      instr:     iw_instr,
      opc:       iw_opc,
      tgt_gp:    iw_tgt_gp,
      tgt_gp_we: iw_tgt_gp_we,
      tgt_sr:    iw_tgt_sr,
      tgt_sr_we: iw_tgt_sr_we,
      tgt_ar:    iw_tgt_ar,
      tgt_ar_we: iw_tgt_ar_we,
      result:    iw_result,
      ar_result: iw_ar_result,
      sr_result: iw_sr_result
   };

   assign mem_op = (opc_is_load(iw_opc) | opc_is_store(iw_opc))
                 & ~iw_flush;

   ma_req_fsm #(
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .iw_clk      (iw_clk),
      .iw_rst      (iw_rst),
      .mem_op      (mem_op),
      .iw_stall    (iw_stall),
      .iw_mem_ack  (mem.iw_mem_ack),
      .req         (req),
      .err         (ow_mem_err),
      .stall       (ow_stall),
      .start       (start),
      .pass        (pass),
      .ack_commit  (ack_commit),
      .ack_hold    (ack_hold),
      .done_commit (done_commit),
      .abort       (abort)
   );

   // Transaction registers, pending bundle and output bundle.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         out_q   <= '0;
         pend_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         unique case (1'b1)
            start: begin
               addr_q  <= iw_addr;
               wdata_q <= iw_result;
               we_q    <= opc_is_store(iw_opc);
               pend_q  <= in_wb;
               out_q   <= wb_bubble(out_q);
            end
            pass: begin
               out_q <= iw_flush ? wb_bubble(in_wb) : in_wb;
            end
            ack_commit: begin
               out_q <= commit_wb(pend_q, mem.iw_mem_rdata, we_q);
            end
            ack_hold: begin
               if (!we_q) pend_q.result <= mem.iw_mem_rdata;
            end
            done_commit: begin
               out_q <= commit_wb(pend_q, pend_q.result, we_q);
            end
            abort: begin
               out_q <= wb_bubble(out_q);
            end
            default: ;
         endcase
      end
   end

   assign mem.ow_mem_req   = req;
   assign mem.ow_mem_we    = we_q;
   assign mem.ow_mem_addr  = addr_q;
   assign mem.ow_mem_wdata = wdata_q;

   assign ow_pc        = out_q.pc;
   assign ow_instr     = out_q.instr;
   assign ow_opc       = out_q.opc;
   assign ow_tgt_gp    = out_q.tgt_gp;
   assign ow_tgt_gp_we = out_q.tgt_gp_we;
   assign ow_tgt_sr    = out_q.tgt_sr;
   assign ow_tgt_sr_we = out_q.tgt_sr_we;
   assign ow_tgt_ar    = out_q.tgt_ar;
   assign ow_tgt_ar_we = out_q.tgt_ar_we;
   assign ow_result    = out_q.result;
   assign ow_ar_result = out_q.ar_result;
   assign ow_sr_result = out_q.sr_result;

endmodule

// File: tb/tb_stg_ma.sv
// Directed bench for stg_ma: pass-through, load, store,
// ack under stall, timeout, flush and async reset.
module tb_stg_ma;
   import stg_ma_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [HBIT_ADDR:0]   pc;
   logic [HBIT_DATA:0]   instr;
   logic [HBIT_OPC:0]    opc;
   logic [HBIT_TGT_GP:0] tgt_gp;
   logic                 gp_we;
   logic [HBIT_TGT_SR:0] tgt_sr;
   logic                 sr_we;
   logic [HBIT_TGT_AR:0] tgt_ar;
   logic                 ar_we;
   logic [HBIT_ADDR:0]   addr;
   logic [HBIT_DATA:0]   result;
   logic [HBIT_ADDR:0]   ar_result;
   logic [HBIT_ADDR:0]   sr_result;
   logic                 flush;
   logic                 stall;

   logic [HBIT_ADDR:0]   o_pc;
   logic [HBIT_DATA:0]   o_instr;
   logic [HBIT_OPC:0]    o_opc;
   logic [HBIT_TGT_GP:0] o_tgt_gp;
   logic                 o_gp_we;
   logic [HBIT_TGT_SR:0] o_tgt_sr;
   logic                 o_sr_we;
   logic [HBIT_TGT_AR:0] o_tgt_ar;
   logic                 o_ar_we;
   logic [HBIT_DATA:0]   o_result;
   logic [HBIT_ADDR:0]   o_ar_result;
   logic [HBIT_ADDR:0]   o_sr_result;
   logic                 o_err;
   logic                 o_stall;

   int checks = 0;
   int fails  = 0;

   stg_ma_if mem ();

   stg_ma #(.TIMEOUT(4)) dut (
      .iw_clk       (clk),
      .iw_rst       (rst),
      .iw_pc        (pc),
      .ow_pc        (o_pc),
      .iw_instr     (instr),
      .ow_instr     (o_instr),
      .iw_opc       (opc),
      .ow_opc       (o_opc),
      .iw_tgt_gp    (tgt_gp),
      .iw_tgt_gp_we (gp_we),
      .ow_tgt_gp    (o_tgt_gp),
      .ow_tgt_gp_we (o_gp_we),
      .iw_tgt_sr    (tgt_sr),
      .iw_tgt_sr_we (sr_we),
      .ow_tgt_sr    (o_tgt_sr),
      .ow_tgt_sr_we (o_sr_we),
      .iw_tgt_ar    (tgt_ar),
      .iw_tgt_ar_we (ar_we),
      .ow_tgt_ar    (o_tgt_ar),
      .ow_tgt_ar_we (o_ar_we),
      .iw_addr      (addr),
      .iw_result    (result),
      .ow_result    (o_result),
      .iw_ar_result (ar_result),
      .ow_ar_result (o_ar_result),
      .iw_sr_result (sr_result),
      .ow_sr_result (o_sr_result),
      .mem          (mem.master),
      .ow_mem_err   (o_err),
      .iw_flush     (flush),
      .iw_stall     (stall),
      .ow_stall     (o_stall)
   );

   task automatic drive_nop();
      opc              = OPC_NOP;
      instr            = '0;
      gp_we            = 1'b0;
      sr_we            = 1'b0;
      ar_we            = 1'b0;
      flush            = 1'b0;
      stall            = 1'b0;
      mem.iw_mem_ack   = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL rst_req: got %b want 0", mem.ow_mem_req);
      end
      checks++;
      if (o_stall !== 1'b0 || o_err !== 1'b0) begin
         fails++;
         $display("FAIL rst_stall_err: got %b%b want 00",
                  o_stall, o_err);
      end
      checks++;
      if (o_result !== '0 || o_pc !== '0 || o_gp_we !== 1'b0) begin
         fails++;
         $display("FAIL rst_out: res %h pc %h we %b want 0",
                  o_result, o_pc, o_gp_we);
      end
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_pass_through();
      opc    = OPC_ADDUR;
      result = 24'h123456;
      tgt_gp = 4'd3;
      gp_we  = 1'b1;
      pc     = 48'h40;
      instr  = 24'h010203;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b0 || mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL pt_stall_req: got %b%b want 00",
                  o_stall, mem.ow_mem_req);
      end
      next_cycle();
      drive_nop();
      @(negedge clk);
      checks++;
      if (o_result !== 24'h123456) begin
         fails++;
         $display("FAIL pt_result: got %h want 123456", o_result);
      end
      checks++;
      if (o_tgt_gp !== 4'd3 || o_gp_we !== 1'b1) begin
         fails++;
         $display("FAIL pt_tgt: got %0d/%b want 3/1",
                  o_tgt_gp, o_gp_we);
      end
      checks++;
      if (o_opc !== OPC_ADDUR || o_pc !== 48'h40) begin
         fails++;
         $display("FAIL pt_opc_pc: got %h/%h want 01/40",
                  o_opc, o_pc);
      end
      checks++;
      if (mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL pt_noreq: got %b want 0", mem.ow_mem_req);
      end
      next_cycle();
   endtask

   task automatic test_load();
      int nstall;
      nstall = 0;
      opc    = OPC_LDUR;
      addr   = 48'h100;
      tgt_gp = 4'd5;
      gp_we  = 1'b1;
      result = '0;
      instr  = 24'h300500;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (o_stall) nstall++;
         if (i > 0) begin
            checks++;
            if (mem.ow_mem_req !== 1'b1 ||
                mem.ow_mem_addr !== 48'h100 ||
                mem.ow_mem_we !== 1'b0) begin
               fails++;
               $display("FAIL ld_req: req %b addr %h we %b",
                        mem.ow_mem_req, mem.ow_mem_addr,
                        mem.ow_mem_we);
            end
            checks++;
            if (o_gp_we !== 1'b0 || o_opc !== '0) begin
               fails++;
               $display("FAIL ld_bubble: we %b opc %h want 0/0",
                        o_gp_we, o_opc);
            end
         end
         next_cycle();
      end
      mem.iw_mem_ack   = 1'b1;
      mem.iw_mem_rdata = 24'hCAFE01;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b0) begin
         fails++;
         $display("FAIL ld_stall_ack: got %b want 0", o_stall);
      end
      checks++;
      if (nstall !== 4) begin
         fails++;
         $display("FAIL ld_stall_cnt: got %0d want 4", nstall);
      end
      next_cycle();
      drive_nop();
      @(negedge clk);
      checks++;
      if (o_result !== 24'hCAFE01 || o_gp_we !== 1'b1 ||
          o_tgt_gp !== 4'd5) begin
         fails++;
         $display("FAIL ld_commit: res %h we %b tgt %0d",
                  o_result, o_gp_we, o_tgt_gp);
      end
      checks++;
      if (mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL ld_req_drop: got %b want 0",
                  mem.ow_mem_req);
      end
      next_cycle();
   endtask

   task automatic test_store();
      opc    = OPC_STUR;
      addr   = 48'h200;
      result = 24'hABCDEF;
      tgt_gp = 4'd2;
      gp_we  = 1'b1;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b1) begin
         fails++;
         $display("FAIL st_stall: got %b want 1", o_stall);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b1 || mem.ow_mem_we !== 1'b1 ||
          mem.ow_mem_wdata !== 24'hABCDEF ||
          mem.ow_mem_addr !== 48'h200) begin
         fails++;
         $display("FAIL st_req: req %b we %b wd %h addr %h",
                  mem.ow_mem_req, mem.ow_mem_we,
                  mem.ow_mem_wdata, mem.ow_mem_addr);
      end
      next_cycle();
      mem.iw_mem_ack   = 1'b1;
      mem.iw_mem_rdata = 24'h555555;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b0) begin
         fails++;
         $display("FAIL st_stall_ack: got %b want 0", o_stall);
      end
      next_cycle();
      drive_nop();
      @(negedge clk);
      checks++;
      if (o_gp_we !== 1'b0 || o_result !== 24'hABCDEF ||
          o_opc !== OPC_STUR) begin
         fails++;
         $display("FAIL st_commit: we %b res %h opc %h",
                  o_gp_we, o_result, o_opc);
      end
      next_cycle();
   endtask

   task automatic test_ack_under_stall();
      opc    = OPC_LDUR;
      addr   = 48'h300;
      tgt_gp = 4'd7;
      gp_we  = 1'b1;
      result = '0;
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b1) begin
         fails++;
         $display("FAIL as_req: got %b want 1", mem.ow_mem_req);
      end
      next_cycle();
      mem.iw_mem_ack   = 1'b1;
      mem.iw_mem_rdata = 24'h123ABC;
      stall            = 1'b1;
      next_cycle();
      drive_nop();
      stall = 1'b1;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b1 || mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL as_done: stall %b req %b want 1/0",
                  o_stall, mem.ow_mem_req);
      end
      checks++;
      if (o_gp_we !== 1'b0 || o_opc !== '0) begin
         fails++;
         $display("FAIL as_hold: we %b opc %h want 0/0",
                  o_gp_we, o_opc);
      end
      next_cycle();
      stall            = 1'b0;
      mem.iw_mem_ack   = 1'b1;
      mem.iw_mem_rdata = 24'hBAD000;
      @(negedge clk);
      checks++;
      if (o_gp_we !== 1'b0) begin
         fails++;
         $display("FAIL as_early: we %b want 0", o_gp_we);
      end
      next_cycle();
      mem.iw_mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (o_result !== 24'h123ABC || o_gp_we !== 1'b1 ||
          o_tgt_gp !== 4'd7) begin
         fails++;
         $display("FAIL as_commit: res %h we %b tgt %0d",
                  o_result, o_gp_we, o_tgt_gp);
      end
      next_cycle();
   endtask

   task automatic test_timeout();
      int nreq;
      int nerr;
      int last_req;
      int err_at;
      logic adv;
      nreq     = 0;
      nerr     = 0;
      last_req = -1;
      err_at   = -1;
      opc      = OPC_LDUR;
      addr     = 48'h400;
      gp_we    = 1'b1;
      sr_we    = 1'b1;
      ar_we    = 1'b1;
      @(negedge clk);
      adv = ~o_stall;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         if (adv) drive_nop();
         @(negedge clk);
         if (mem.ow_mem_req) begin
            nreq++;
            last_req = i;
         end
         if (o_err) begin
            nerr++;
            err_at = i;
            checks++;
            if (o_gp_we !== 1'b0 || o_sr_we !== 1'b0 ||
                o_ar_we !== 1'b0) begin
               fails++;
               $display("FAIL to_bubble: we %b%b%b want 000",
                        o_gp_we, o_sr_we, o_ar_we);
            end
         end
         adv = ~o_stall;
      end
      checks++;
      if (nreq !== 4) begin
         fails++;
         $display("FAIL to_req_cycles: got %0d want 4", nreq);
      end
      checks++;
      if (nerr !== 1 || err_at !== last_req + 1) begin
         fails++;
         $display("FAIL to_err: got %0d at %0d want 1 at %0d",
                  nerr, err_at, last_req + 1);
      end
      checks++;
      if (o_stall !== 1'b0 || mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL to_idle: stall %b req %b want 0/0",
                  o_stall, mem.ow_mem_req);
      end
      next_cycle();
   endtask

   task automatic test_flush();
      opc    = OPC_ADDUR;
      gp_we  = 1'b1;
      sr_we  = 1'b1;
      ar_we  = 1'b1;
      result = 24'h0F0F0F;
      instr  = 24'h111111;
      next_cycle();
      opc   = OPC_LDUR;
      addr  = 48'h500;
      instr = 24'h222222;
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b0 || o_stall !== 1'b0) begin
         fails++;
         $display("FAIL fl_nostall: req %b stall %b want 0/0",
                  mem.ow_mem_req, o_stall);
      end
      checks++;
      if (o_gp_we !== 1'b1 || o_instr !== 24'h111111) begin
         fails++;
         $display("FAIL fl_prev: we %b instr %h want 1/111111",
                  o_gp_we, o_instr);
      end
      next_cycle();
      drive_nop();
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b0) begin
         fails++;
         $display("FAIL fl_noreq: got %b want 0", mem.ow_mem_req);
      end
      checks++;
      if (o_opc !== '0 || o_instr !== '0 || o_gp_we !== 1'b0 ||
          o_sr_we !== 1'b0 || o_ar_we !== 1'b0) begin
         fails++;
         $display("FAIL fl_bubble: opc %h ins %h we %b%b%b",
                  o_opc, o_instr, o_gp_we, o_sr_we, o_ar_we);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_wait();
      opc    = OPC_LDUR;
      addr   = 48'h600;
      result = 24'h00AA00;
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b1 ||
          mem.ow_mem_addr !== 48'h600) begin
         fails++;
         $display("FAIL rw_req: req %b addr %h want 1/600",
                  mem.ow_mem_req, mem.ow_mem_addr);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (mem.ow_mem_req !== 1'b0 || mem.ow_mem_addr !== '0) begin
         fails++;
         $display("FAIL rw_async: req %b addr %h want 0/0",
                  mem.ow_mem_req, mem.ow_mem_addr);
      end
      checks++;
      if (o_stall !== 1'b0 || o_pc !== '0 ||
          o_result !== '0 || o_err !== 1'b0) begin
         fails++;
         $display("FAIL rw_outs: st %b pc %h res %h err %b",
                  o_stall, o_pc, o_result, o_err);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_nop();
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem.ow_mem_req !== 1'b0 || o_stall !== 1'b0) begin
         fails++;
         $display("FAIL rw_after: req %b stall %b want 0/0",
                  mem.ow_mem_req, o_stall);
      end
   endtask

   initial begin
      pc               = '0;
      tgt_gp           = '0;
      tgt_sr           = 2'd1;
      tgt_ar           = 2'd2;
      addr             = '0;
      result           = '0;
      ar_result        = 48'h1111;
      sr_result        = 48'h2222;
      mem.iw_mem_rdata = '0;
      drive_nop();
      test_reset();
      test_pass_through();
      test_load();
      test_store();
      test_ack_under_stall();
      test_timeout();
      test_flush();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
